// File: rtl/tph_pkg.sv
// Shared types and defaults for the two-phase bundled-data receive bridge.
// The optional rx_count statistics port is enabled by defining TPH_RX_STATS_EN.
package tph_pkg;

    typedef logic phase_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_STALL = 1'b1
    } rx_state_t;

    localparam int TPH_WIDTH_DEF = 12;
    localparam int TPH_DEPTH_DEF = 4;
    localparam int TPH_SYNC_DEF  = 2;

    // A token is outstanding whenever the synchronised request phase differs from the last one served.
    function automatic logic tokenPending(input phase_t reqSync, input phase_t reqSeen);
        return reqSync ^ reqSeen;
    endfunction

endpackage

// File: rtl/tph_sync.sv
// Reset-to-zero flop chain that brings the asynchronous request phase into the clk domain.
module tph_sync
    import tph_pkg::*;
#(
    parameter int SYNC_STAGES = TPH_SYNC_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  phase_t level,
    output phase_t synced
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], level};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tph_rx_bridge.sv
// Receiving end of the 2-phase req/ack bundled-data channel feeding a valid/ready FIFO.
// Define TPH_RX_STATS_EN to add the 16-bit rx_count captured-token counter.
module tph_rx_bridge
    import tph_pkg::*;
#(
    parameter int WIDTH       = TPH_WIDTH_DEF,
    parameter int DEPTH       = TPH_DEPTH_DEF,
    parameter int SYNC_STAGES = TPH_SYNC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_in,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   ack_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef TPH_RX_STATS_EN
    ,
    output logic [15:0]            rx_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    phase_t           reqSync;
    phase_t           reqSeen;
    rx_state_t        state;
    logic             tok;
    logic             full;
    logic             capture;
    logic             pop;
    logic             stageValid;
    logic [WIDTH-1:0] stageData;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    tph_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) reqSyncInst (
        .clk   (clk),
        .reset (reset),
        .level (req_in),
        .synced(reqSync)
    );

    assign tok     = tokenPending(reqSync, reqSeen);
    assign full    = (count == CNT_W'(DEPTH));
    assign capture = tok && !full;
    assign pop     = out_valid && out_ready;

    // Captured words sit one clock in the staging register before entering the FIFO,
    // so the head becomes visible the cycle after the ack toggles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_IDLE;
            reqSeen    <= 1'b0;
            ack_out    <= 1'b0;
            stageValid <= 1'b0;
            stageData  <= '0;
        end else begin
            stageValid <= capture;
            if (capture) begin
                stageData <= data_in;
                reqSeen   <= reqSync;
                ack_out   <= ~ack_out;
            end
            case (state)
                RX_IDLE: begin
                    if (tok && full) begin
                        state <= RX_STALL;
                    end
                end
                RX_STALL: begin
                    if (!full) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && stageValid) begin
            mem[wrPtr] <= stageData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (stageValid) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({stageValid, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rdPtr] : '0;
    assign fifo_count = count;

`ifdef TPH_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count <= '0;
        end else if (capture) begin
            rx_count <= rx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tph_rx_bridge.sv
// Self-checking bench for tph_rx_bridge: queue-based reference model plus directed literal checks.
module tb_tph_rx_bridge;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       fifo_count;
`ifdef TPH_RX_STATS_EN
    logic [15:0]      rx_count;
`endif

    int passCount  = 0;
    int checkCount = 0;

    tph_rx_bridge #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_count(fifo_count)
`ifdef TPH_RX_STATS_EN
        ,
        .rx_count  (rx_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: request seen through SYNC delay cycles, a word queue, and a one-cycle landing slot.
    bit               modelArmed = 1'b0;
    logic [SYNC-1:0]  mHist;
    logic             mSeen;
    logic [WIDTH-1:0] mq[$];
    bit               mLandPend;
    logic [WIDTH-1:0] mLandWord;
    int               mTokens;
    logic             mReqSync;
    bit               mDoPop;
    bit               mDoPush;

    always @(posedge clk) begin
        if (reset) begin
            modelArmed = 1'b1;
            mHist      = '0;
            mSeen      = 1'b0;
            mq.delete();
            mLandPend  = 1'b0;
            mLandWord  = '0;
            mTokens    = 0;
        end else if (modelArmed) begin
            mReqSync = mHist[SYNC-1];
            mDoPop   = out_ready && (mq.size() > 0);
            mDoPush  = (mReqSync != mSeen) && (mq.size() < DEPTH);
            if (mDoPop) void'(mq.pop_front());
            if (mLandPend) mq.push_back(mLandWord);
            mLandPend = mDoPush;
            if (mDoPush) begin
                mLandWord = data_in;
                mSeen     = mReqSync;
                mTokens   = (mTokens + 1) % 65536;
            end
            mHist = {mHist[SYNC-2:0], req_in};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelArmed) begin
            checkOutput("model.ack", 32'(ack_out), 32'(mSeen));
            checkOutput("model.valid", 32'(out_valid), 32'(mq.size() > 0));
            checkOutput("model.data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            checkOutput("model.count", 32'(fifo_count), 32'(mq.size()));
`ifdef TPH_RX_STATS_EN
            checkOutput("model.rxCount", 32'(rx_count), 32'(mTokens));
`endif
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit toggle, input bit rdy);
        #1;
        data_in   = d;
        out_ready = rdy;
        if (toggle) req_in = ~req_in;
    endtask

    task automatic waitAck(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack_out == req_in) seen = 1'b1;
        end
        if (!seen) begin
            checkCount++;
            $display("[TB] FAIL %s: ack timeout, ack_out=%0b req_in=%0b", name, ack_out, req_in);
        end
    endtask

    task automatic sendToken(input logic [WIDTH-1:0] d, input bit rdy);
        applyStimulus(d, 1'b1, rdy);
        waitAck("sendToken");
    endtask

    task automatic doReset(input bit keepReq);
        #1;
        reset     = 1'b1;
        out_ready = 1'b0;
        if (!keepReq) req_in = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;

        // Test 1: reset held two clocks.
        repeat (2) @(negedge clk);
        checkOutput("t1.ack", 32'(ack_out), 32'd0);
        checkOutput("t1.valid", 32'(out_valid), 32'd0);
        checkOutput("t1.data", 32'(out_data), 32'd0);
        checkOutput("t1.count", 32'(fifo_count), 32'd0);
        #1 reset = 1'b0;

        // Test 2: single token latency.
        applyStimulus(12'h0A5, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2.ackS1", 32'(ack_out), 32'd0);
        @(negedge clk);
        checkOutput("t2.ackS2", 32'(ack_out), 32'd0);
        @(negedge clk);
        checkOutput("t2.ackS3", 32'(ack_out), 32'd1);
        checkOutput("t2.validS3", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("t2.validS4", 32'(out_valid), 32'd1);
        checkOutput("t2.dataS4", 32'(out_data), 32'h0A5);
        checkOutput("t2.countS4", 32'(fifo_count), 32'd1);

        // Test 3: fill, stall the fifth token, release with a single pop.
        doReset(1'b0);
        for (int i = 1; i <= 4; i++) sendToken(WIDTH'(i), 1'b0);
        applyStimulus(12'h005, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("t3.stallAck", 32'(ack_out), 32'd0);
        checkOutput("t3.stallCount", 32'(fifo_count), 32'd4);
        checkOutput("t3.stallHead", 32'(out_data), 32'h001);
        applyStimulus(12'h005, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t3.popCount", 32'(fifo_count), 32'd3);
        checkOutput("t3.popAck", 32'(ack_out), 32'd0);
        applyStimulus(12'h005, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3.lateAck", 32'(ack_out), 32'd1);
        @(negedge clk);
        checkOutput("t3.refillCount", 32'(fifo_count), 32'd4);
        checkOutput("t3.refillHead", 32'(out_data), 32'h002);

        // Test 4: push and pop land on the same clock at occupancy 2.
        doReset(1'b0);
        sendToken(12'h002, 1'b0);
        sendToken(12'h003, 1'b0);
        @(negedge clk);
        checkOutput("t4.preCount", 32'(fifo_count), 32'd2);
        sendToken(12'h0AB, 1'b0);
        checkOutput("t4.ackHead", 32'(out_data), 32'h002);
        applyStimulus(12'h0AB, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t4.bothCount", 32'(fifo_count), 32'd2);
        checkOutput("t4.bothHead", 32'(out_data), 32'h003);
        @(negedge clk);
        checkOutput("t4.drainHead", 32'(out_data), 32'h0AB);
        checkOutput("t4.drainCount", 32'(fifo_count), 32'd1);
        @(negedge clk);
        checkOutput("t4.emptyData", 32'(out_data), 32'd0);
        checkOutput("t4.emptyValid", 32'(out_valid), 32'd0);
        applyStimulus(12'h0AB, 1'b0, 1'b0);

        // Test 5: reset mid-operation with an unacked request high.
        doReset(1'b0);
        sendToken(12'h011, 1'b0);
        sendToken(12'h022, 1'b0);
        sendToken(12'h033, 1'b0);
        @(negedge clk);
        applyStimulus(12'h033, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(12'h033, 1'b0, 1'b0);
        sendToken(12'h044, 1'b0);
        @(negedge clk);
        checkOutput("t5.preCount", 32'(fifo_count), 32'd3);
        applyStimulus(12'h5C3, 1'b1, 1'b0);
        @(negedge clk);
        doReset(1'b1);
        checkOutput("t5.rstCount", 32'(fifo_count), 32'd0);
        @(negedge clk);
        checkOutput("t5.ackS1", 32'(ack_out), 32'd0);
        @(negedge clk);
        checkOutput("t5.ackS2", 32'(ack_out), 32'd0);
        @(negedge clk);
        checkOutput("t5.ackS3", 32'(ack_out), 32'd1);
        @(negedge clk);
        checkOutput("t5.count", 32'(fifo_count), 32'd1);
        checkOutput("t5.head", 32'(out_data), 32'h5C3);

`ifdef TPH_RX_STATS_EN
        // Test 6: token statistics counter.
        doReset(1'b0);
        @(negedge clk);
        checkOutput("t6.rxZero", 32'(rx_count), 32'd0);
        for (int i = 0; i < 7; i++) sendToken(WIDTH'(12'h100 + i), 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("t6.rxSeven", 32'(rx_count), 32'd7);
        doReset(1'b0);
        @(negedge clk);
        checkOutput("t6.rxReset", 32'(rx_count), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
